// File: rtl/execute_multdiv_if.sv
// Operand/request and result/status bundle between the execute-stage pipeline
// registers and the iterative multiply/divide unit.
interface execute_multdiv_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/execute_multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit;
// 32 steps per operation, registered result, one-cycle ready strobe.
//
// state | meaning
// IDLE  | waiting for a request, result held
// MULT  | Booth step per edge, busy
// DIV   | restoring divide step per edge, busy
// DONE  | result just written, ready strobe, may accept a new request
module execute_multdiv (
    input  logic               clock,
    input  logic               reset,
    execute_multdiv_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [32:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic [32:0] opb;
    logic        div_neg;
    logic        div_zero;
    logic        div_ovf;

    // acc/q are the Booth product register for MULT and remainder/quotient for DIV;
    // opb is the sign-extended multiplicand or the divisor magnitude.
    logic [32:0] booth_sum;
    logic [32:0] booth_next_acc;
    logic [31:0] booth_next_q;
    logic [32:0] mult_hi;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_take;
    logic [32:0] div_next_rem;
    logic [31:0] div_next_q;
    logic [31:0] div_quot;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + opb;
            2'b10:   booth_sum = acc - opb;
            default: booth_sum = acc;
        endcase
    end

    assign booth_next_acc = {booth_sum[32], booth_sum[32:1]};
    assign booth_next_q   = {booth_sum[0], q[31:1]};
    assign mult_hi        = {booth_next_acc[31:0], booth_next_q[31]};

    assign div_shift    = {acc[31:0], q[31]};
    assign div_diff     = {1'b0, div_shift} - {1'b0, opb};
    assign div_take     = ~div_diff[33];
    assign div_next_rem = div_take ? div_diff[32:0] : div_shift;
    assign div_next_q   = {q[30:0], div_take};
    assign div_quot     = div_neg ? (~div_next_q + 32'd1) : div_next_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            count              <= 6'd0;
            acc                <= 33'd0;
            q                  <= 32'd0;
            q_m1               <= 1'b0;
            opb                <= 33'd0;
            div_neg            <= 1'b0;
            div_zero           <= 1'b0;
            div_ovf            <= 1'b0;
            bus.data_result    <= 32'd0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.ctrl_MULT) begin
                        state    <= MULT;
                        bus.busy <= 1'b1;
                        count    <= 6'd0;
                        acc      <= 33'd0;
                        q        <= bus.data_operandB;
                        q_m1     <= 1'b0;
                        opb      <= {bus.data_operandA[31], bus.data_operandA};
                    end else if (bus.ctrl_DIV) begin
                        state    <= DIV;
                        bus.busy <= 1'b1;
                        count    <= 6'd0;
                        acc      <= 33'd0;
                        q        <= magnitude(bus.data_operandA);
                        q_m1     <= 1'b0;
                        opb      <= {1'b0, magnitude(bus.data_operandB)};
                        div_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
                        div_zero <= (bus.data_operandB == 32'd0);
                        div_ovf  <= (bus.data_operandA == 32'h8000_0000) &&
                                    (bus.data_operandB == 32'hFFFF_FFFF);
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                MULT: begin
                    acc   <= booth_next_acc;
                    q     <= booth_next_q;
                    q_m1  <= q[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state              <= DONE;
                        bus.busy           <= 1'b0;
                        bus.data_resultRDY <= 1'b1;
                        bus.data_result    <= booth_next_q;
                        bus.data_exception <= !((&mult_hi) || (~|mult_hi));
                    end
                end
                DIV: begin
                    acc   <= div_next_rem;
                    q     <= div_next_q;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state              <= DONE;
                        bus.busy           <= 1'b0;
                        bus.data_resultRDY <= 1'b1;
                        bus.data_result    <= div_zero ? 32'd0 : div_quot;
                        bus.data_exception <= div_zero | div_ovf;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/execute_multdiv.md
# execute_multdiv

Iterative signed 32-bit multiply/divide unit in the execute stage, between the decode/execute and execute/memory pipeline registers. It consumes the decoded operands presented by the decode/execute register. It produces a result and an overflow/exception flag for the execute/memory register. While it computes, its `busy` output deasserts the enables of the PC, fetch/decode and decode/execute registers.

## Interface
- No parameters; operand and result width fixed at 32.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ctrl_MULT`  in  1  start-multiply request, sampled on rising edge.
- `ctrl_DIV`  in  1  start-divide request, sampled on rising edge.
- `data_operandA`  in  32  multiplicand / dividend, two's complement.
- `data_operandB`  in  32  multiplier / divisor, two's complement.
- `data_result`  out  32  product low word / quotient.
- `data_exception`  out  1  overflow or divide-by-zero for the current result.
- `data_resultRDY`  out  1  one-cycle completion strobe.
- `busy`  out  1  operation in progress; pipeline stall request.

## Operation
- States: IDLE, MULT, DIV, DONE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE, on an edge where `ctrl_MULT` or `ctrl_DIV` is high.
  - On acceptance, operands are captured, the 6-bit iteration counter is cleared, and the state moves to MULT or DIV.
  - If both requests are high, multiply wins and `ctrl_DIV` is ignored.
  - Requests while in MULT or DIV are ignored; the captured operands are not disturbed.
- MULT:
  - Radix-2 Booth algorithm over a 65-bit {A, Q, q-1} product register, with a 33-bit signed adder, one step per edge, 32 steps.
  - Result = low 32 bits of the 64-bit signed product.
  - `data_exception` = 1 if product bits [63:31] are not all equal (product not representable in signed 32 bits).
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per edge, 32 steps.
  - Quotient is negated if operand signs differ; it truncates toward zero; the remainder is discarded.
  - Divisor 0: result 0, exception 1.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
  - Exceptional cases still take the full 32 steps (uniform latency).
- DONE:
  - Lasts exactly one cycle; `data_resultRDY` = 1.
  - Next state is IDLE, or MULT/DIV if a new start is accepted on this edge (back-to-back issue).
- Output holding:
  - `data_result` and `data_exception` are registered and update only on the edge entering DONE.
  - They hold their values through IDLE and through the next operation until its completion.
- `busy` = 1 exactly in the MULT and DIV states.
- Reset:
  - Asserting `reset` low at any time, including mid-operation, forces IDLE immediately.
  - The operation is aborted with no `data_resultRDY`.
  - All outputs go to 0.

## Timing
- Reset values: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0, counter = 0.
- Start accepted at edge E0.
- `busy` is high from after E0 through the cycle ending at E32 (32 cycles).
- Steps execute at edges E1–E32; the counter reaches 32 at E32.
- The state enters DONE at E32. After E32, `data_result`/`data_exception` are valid, `data_resultRDY` = 1 and `busy` = 0 for one cycle.
- `data_resultRDY` falls after E33 unless the same condition recurs from a back-to-back start (a new DONE cannot occur sooner than E33+32).
- Operand inputs matter only at the acceptance edge.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.
- The request inputs are levels sampled per edge; the upstream logic holds them for one cycle.

## Test plan
- Reset, then `ctrl_MULT` with A = 7, B = 0xFFFFFFFD (−3) -> `busy` high exactly 32 cycles; then `data_result` = 0xFFFFFFEB, `data_exception` = 0, one-cycle `data_resultRDY`.
- Multiply 0x00010000 × 0x00010000 -> result 0x00000000, exception 1. Multiply 0x80000000 × 1 -> 0x80000000, exception 0.
- Divide 0xFFFFFFEF (−17) / 5 -> 0xFFFFFFFD, exception 0. Divide 17 / 0xFFFFFFFB -> 0xFFFFFFFD. Divide 100 / 7 -> 14.
- Divide 5 / 0 -> result 0, exception 1, after the same 32-cycle latency. Divide 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
- Start a divide in the DONE cycle of a multiply -> accepted; `busy` rises with no IDLE gap. Pulse `ctrl_MULT` during `busy` -> ignored; the result is unchanged. Assert both requests together -> multiply is performed.
- Assert `reset` low at step 10 of a multiply -> all outputs 0 immediately; `data_resultRDY` never pulses. After release, a new divide 9 / 3 -> 3 completes normally.
